sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single SRAM-like data port between two requesters: instruction fetch (id 0) and the load/store path (id 1).
- Request side uses a req/addr_ok handshake and the response side uses data_ok.
- Issues requests in order, keeps a small in-order ID FIFO of outstanding requests, and routes each response back to the requester that issued it.
- Also generates the byte write strobes from size and address.

Parameters:
- MAX_OUTSTANDING, 2, depth of the outstanding-request ID FIFO (power of 2, ≥1).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address (reads only)
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data returned
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  32  store data, already lane-aligned
- data_addr_ok  out  1  load/store request accepted
- data_data_ok  out  1  load data returned / store acknowledged
- data_rdata  out  32  load data
- m_req  out  1  request to memory
- m_wr  out  1  write enable
- m_size  out  2  access size
- m_addr  out  ADDR_W  address
- m_wstrb  out  4  byte strobes
- m_wdata  out  32  write data
- m_addr_ok  in  1  memory accepted request
- m_data_ok  in  1  memory response valid
- m_rdata  in  32  response data

Behaviour:
- State: ID FIFO (MAX_OUTSTANDING × 1 bit, plus rd/wr pointers and count), lock_valid, lock_id. Reset asserts asynchronously: FIFO empty, lock_valid=0.
- Outputs are combinational from state and inputs. With no requests after reset, every output is 0.
- full = (count==MAX_OUTSTANDING).
- Grant selection:
  - If lock_valid, sel = lock_id.
  - Otherwise sel = 1 if data_req, else 0 if inst_req.
  - Data path has fixed priority.
- m_req = !full && (sel requester's req). Master fields come from sel: inst always drives m_wr=0 and m_size=2.
- Lock:
  - When m_req=1 && m_addr_ok=0: lock_valid<=1, lock_id<=sel.
  - When m_req && m_addr_ok: lock_valid<=0.
  - A request presented to memory therefore cannot be switched, even if data_req rises later.
- Requesters hold req and their fields stable until addr_ok. Withdrawing a request is illegal.
- Acceptance: inst_addr_ok = m_req && m_addr_ok && sel==0; data_addr_ok likewise with sel==1. On accept, push sel into the FIFO.
- Full: while full, m_req=0 and no addr_ok is given, even if a pop occurs in the same cycle (no bypass).
- Response:
  - On m_data_ok with FIFO non-empty, pop the head. Head==0 → inst_data_ok=1; head==1 → data_data_ok=1.
  - inst_rdata = data_rdata = m_rdata unconditionally.
  - m_data_ok with FIFO empty is ignored and has no state change.
- Simultaneous push and pop: count unchanged, both pointers advance. A response and a new acceptance may share a cycle.
- Latency: zero added cycles on both the request and response paths.
- Strobes:
  - Loads and fetches: m_wstrb=0.
  - Stores, size 0: 4'b0001<<addr[1:0].
  - Stores, size 1: addr[1] ? 4'b1100 : 4'b0011.
  - Stores, size 2 or 3: 4'b1111.
- Pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction clears the FIFO and lock. Responses already in flight are then ignored.

Test Plan:
- Reset, then inst_req=1, addr=0x1c000000, m_addr_ok=1 → inst_addr_ok=1, m_wr=0, m_wstrb=0. Next cycle m_data_ok=1, rdata=0x12345678 → inst_data_ok=1, inst_rdata=0x12345678, data_data_ok=0.
- inst_req and data_req both high, data store size 0, addr=0x...3, m_addr_ok=1 → data wins, m_wstrb=4'b1000, m_wr=1, inst_addr_ok=0.
- Lock: inst_req alone with m_addr_ok=0 for 3 cycles, data_req rises in cycle 2 → m_addr stays the inst address until m_addr_ok. Inst is accepted first, data in the following cycle.
- Full: accept two requests (inst, then data) with no m_data_ok → m_req=0 and no addr_ok while full. Then m_data_ok twice → inst_data_ok, then data_data_ok, in order.
- Concurrent: FIFO count=1 (inst), data request accepted in the same cycle as m_data_ok → inst_data_ok=1, count stays 1, head=data.
- Async reset asserted mid-clock with count=2 → count=0 and lock cleared immediately. A subsequent stray m_data_ok produces no data_ok.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side SRAM-like handshake signals.
// The arbiter sits on the master modport; the environment drives the slave modport.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    logic              m_req;
    logic              m_wr;
    logic [1:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_wdata;
    logic              m_addr_ok;
    logic              m_data_ok;
    logic [31:0]       m_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch (id 0) and load/store (id 1); an in-order
// ID FIFO routes each response to its issuer. Outputs are combinational, zero latency.
module sram_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.master  bus
);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       lock_valid_q, lock_valid_d;
    logic                       lock_id_q, lock_id_d;

    logic              full_c;
    logic              sel_c;
    logic              m_req_c;
    logic              accept_c;
    logic              pop_c;
    logic              head_c;
    logic [ADDR_W-1:0] addr_sel_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant: a locked (presented but not yet accepted) request keeps the port.
    always_comb begin
        full_c     = (count_q == CNT_W'(MAX_OUTSTANDING));
        sel_c      = lock_valid_q ? lock_id_q : bus.data_req;
        m_req_c    = !full_c && (sel_c ? bus.data_req : bus.inst_req);
        accept_c   = m_req_c && bus.m_addr_ok;
        pop_c      = bus.m_data_ok && (count_q != '0);
        head_c     = fifo_q[rd_ptr_q];
        addr_sel_c = sel_c ? bus.data_addr : bus.inst_addr;
    end

    // Master-side fields are forced to zero whenever no request is presented.
    always_comb begin
        bus.m_req   = m_req_c;
        bus.m_wr    = 1'b0;
        bus.m_size  = 2'd0;
        bus.m_addr  = '0;
        bus.m_wstrb = 4'b0000;
        bus.m_wdata = 32'd0;
        if (m_req_c) begin
            bus.m_addr = addr_sel_c;
            if (sel_c) begin
                bus.m_wr    = bus.data_wr;
                bus.m_size  = bus.data_size;
                bus.m_wdata = bus.data_wdata;
                if (bus.data_wr) begin
                    case (bus.data_size)
                        2'd0:    bus.m_wstrb = 4'b0001 << bus.data_addr[1:0];
                        2'd1:    bus.m_wstrb = bus.data_addr[1] ? 4'b1100 : 4'b0011;
                        default: bus.m_wstrb = 4'b1111;
                    endcase
                end
            end else begin
                bus.m_size = 2'd2;
            end
        end
    end

    always_comb begin
        bus.inst_addr_ok = accept_c && !sel_c;
        bus.data_addr_ok = accept_c && sel_c;
        bus.inst_data_ok = pop_c && !head_c;
        bus.data_data_ok = pop_c && head_c;
        bus.inst_rdata   = bus.m_rdata;
        bus.data_rdata   = bus.m_rdata;
    end

    always_comb begin
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + CNT_W'(accept_c) - CNT_W'(pop_c);
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        if (accept_c) begin
            fifo_d[wr_ptr_q] = sel_c;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (m_req_c && !bus.m_addr_ok) begin
            lock_valid_d = 1'b1;
            lock_id_d    = sel_c;
        end else if (accept_c) begin
            lock_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
        end
    end
endmodule
